// File: rtl/data_sync_tx_if.sv
// Source-side bundle for data_sync_tx: upstream valid/ready word plus the bus/enable pair toward the destination.
// ack_level exists only when DATA_SYNC_TX_ACK_EN is defined.
interface data_sync_tx_if #(
   parameter int BUS_WIDTH = 8
);
   logic [BUS_WIDTH-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [BUS_WIDTH-1:0] unsync_bus;
   logic                 bus_enable;
`ifdef DATA_SYNC_TX_ACK_EN
   logic                 ack_level;

   modport master (output in_data, in_valid, ack_level,
                   input  in_ready, unsync_bus, bus_enable);
   modport slave  (input  in_data, in_valid, ack_level,
                   output in_ready, unsync_bus, bus_enable);
`else
   modport master (output in_data, in_valid,
                   input  in_ready, unsync_bus, bus_enable);
   modport slave  (input  in_data, in_valid,
                   output in_ready, unsync_bus, bus_enable);
`endif
endinterface

// File: rtl/data_sync_tx.sv
// Launches one word per handshake on a held bus framed by a single Bus_Enable window; DATA_SYNC_TX_ACK_EN swaps counts for an ack handshake.
// Latency: bus/enable valid one edge after accept; In_Ready low from accept until HOLD and GAP have both elapsed.
module data_sync_tx #(
   parameter int BUS_WIDTH   = 8
`ifdef DATA_SYNC_TX_ACK_EN
  ,parameter int NUM_STAGES  = 2
`else
  ,parameter int HOLD_CYCLES = 4
  ,parameter int GAP_CYCLES  = 4
`endif
) (
   input logic           clk_i,
   input logic           rst_ni,
   data_sync_tx_if.slave bus_if
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [BUS_WIDTH-1:0] bus_q, bus_d;
   logic                 en_q, en_d;
   logic                 accept;
   logic                 hold_done;
   logic                 gap_done;

   assign accept = bus_if.in_valid & (state_q == IDLE);

`ifdef DATA_SYNC_TX_ACK_EN
   logic [NUM_STAGES-1:0] ack_ff_q;
   logic                  ack_sync;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_ff_q <= '0;
      end else begin
         ack_ff_q <= {ack_ff_q[NUM_STAGES-2:0], bus_if.ack_level};
      end
   end

   assign ack_sync  = ack_ff_q[NUM_STAGES-1];
   assign hold_done = ack_sync;
   assign gap_done  = ~ack_sync;
`else
   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_zero;

   assign cnt_zero  = (cnt_q == '0);
   assign hold_done = cnt_zero;
   assign gap_done  = cnt_zero;

   always_comb begin
      cnt_d = cnt_q;
      case (state_q)
         IDLE:    if (accept) cnt_d = HOLD_LOAD;
         HOLD:    cnt_d = cnt_zero ? GAP_LOAD : cnt_q - 1'b1;
         GAP:     if (!cnt_zero) cnt_d = cnt_q - 1'b1;
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // Bus only loads on accept, so it stays frozen through HOLD and GAP.
   always_comb begin
      state_d = state_q;
      bus_d   = bus_q;
      en_d    = en_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               bus_d   = bus_if.in_data;
               en_d    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (hold_done) begin
               en_d    = 1'b0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_done) state_d = IDLE;
         end
         default: begin
            en_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         bus_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         bus_q   <= bus_d;
         en_q    <= en_d;
      end
   end

   assign bus_if.in_ready   = (state_q == IDLE);
   assign bus_if.unsync_bus = bus_q;
   assign bus_if.bus_enable = en_q;

endmodule
